// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage; issues loads/stores to the memory controller and extends load data for write-back.
// Latency: non-memory ops are combinational; a memory op takes 1 issue cycle + controller cycles + 1 DONE cycle.
// Backpressure: i_rdy=0 freezes all state; o_stall_req holds upstream stages while a memory op is issued and in flight.
module mem_stage #(
    parameter int unsigned   OPT_W  = 6,
    parameter logic [OPT_W-1:0] OP_LB  = 6'd11,
    parameter logic [OPT_W-1:0] OP_LH  = 6'd12,
    parameter logic [OPT_W-1:0] OP_LW  = 6'd13,
    parameter logic [OPT_W-1:0] OP_LBU = 6'd14,
    parameter logic [OPT_W-1:0] OP_LHU = 6'd15,
    parameter logic [OPT_W-1:0] OP_SB  = 6'd16,
    parameter logic [OPT_W-1:0] OP_SH  = 6'd17,
    parameter logic [OPT_W-1:0] OP_SW  = 6'd18
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rdy,
    input  logic [OPT_W-1:0] i_mem_inst,
    input  logic [4:0]       i_mem_rd,
    input  logic [31:0]      i_mem_vd,
    input  logic             i_mem_w_enable,
    input  logic [31:0]      i_mem_memctrl_addr,
    input  logic             i_mc_done,
    input  logic [31:0]      i_mc_rdata,
    output logic             o_mc_req,
    output logic             o_mc_we,
    output logic [31:0]      o_mc_addr,
    output logic [1:0]       o_mc_size,
    output logic [31:0]      o_mc_wdata,
    output logic [4:0]       o_wb_rd,
    output logic [31:0]      o_wb_vd,
    output logic             o_wb_w_enable,
    output logic             o_stall_req
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_mc_req;
    logic        r_mc_we;
    logic [31:0] r_mc_addr;
    logic [1:0]  r_mc_size;
    logic [31:0] r_mc_wdata;
    logic        r_ld_sgn;
    logic [31:0] r_load_q;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic [1:0]  w_size;
    logic        w_ld_sgn;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;

    // Decode the incoming opcode: class, access size and signedness
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = 2'd0;
        w_ld_sgn   = 1'b0;
        case (i_mem_inst)
            OP_LB:  begin w_is_load  = 1'b1; w_size = 2'd0; w_ld_sgn = 1'b1; end
            OP_LH:  begin w_is_load  = 1'b1; w_size = 2'd1; w_ld_sgn = 1'b1; end
            OP_LW:  begin w_is_load  = 1'b1; w_size = 2'd2; end
            OP_LBU: begin w_is_load  = 1'b1; w_size = 2'd0; end
            OP_LHU: begin w_is_load  = 1'b1; w_size = 2'd1; end
            OP_SB:  begin w_is_store = 1'b1; w_size = 2'd0; end
            OP_SH:  begin w_is_store = 1'b1; w_size = 2'd1; end
            OP_SW:  begin w_is_store = 1'b1; w_size = 2'd2; end
            default: ;
        endcase
        w_is_mem = w_is_load | w_is_store;
    end

    // Store data is low-aligned and masked so the controller never sees stale upper bytes
    always_comb begin
        w_wdata = i_mem_vd;
        case (w_size)
            2'd0:    w_wdata = {24'd0, i_mem_vd[7:0]};
            2'd1:    w_wdata = {16'd0, i_mem_vd[15:0]};
            default: w_wdata = i_mem_vd;
        endcase
    end

    // Extend returned load data using the size/signedness latched at issue
    always_comb begin
        w_ext = i_mc_rdata;
        case (r_mc_size)
            2'd0:    w_ext = {{24{r_ld_sgn & i_mc_rdata[7]}},  i_mc_rdata[7:0]};
            2'd1:    w_ext = {{16{r_ld_sgn & i_mc_rdata[15]}}, i_mc_rdata[15:0]};
            default: w_ext = i_mc_rdata;
        endcase
    end

    // Access FSM: issue in IDLE, hold request in WAIT, present result for one DONE cycle
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_mc_req   <= 1'b0;
            r_mc_we    <= 1'b0;
            r_mc_addr  <= 32'd0;
            r_mc_size  <= 2'd0;
            r_mc_wdata <= 32'd0;
            r_ld_sgn   <= 1'b0;
            r_load_q   <= 32'd0;
        end else if (i_rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem) begin
                        r_mc_req   <= 1'b1;
                        r_mc_we    <= w_is_store;
                        r_mc_addr  <= i_mem_memctrl_addr;
                        r_mc_size  <= w_size;
                        r_mc_wdata <= w_wdata;
                        r_ld_sgn   <= w_ld_sgn;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_mc_done) begin
                        r_mc_req <= 1'b0;
                        if (!r_mc_we) begin
                            r_load_q <= w_ext;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The pipeline advances on this edge, so the completed op is never re-issued
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write-back and stall outputs are combinational on state and the EX/MEM inputs
    always_comb begin
        o_wb_rd       = i_mem_rd;
        o_wb_vd       = i_mem_vd;
        o_wb_w_enable = 1'b0;
        o_stall_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_stall_req   = w_is_mem;
                o_wb_w_enable = w_is_mem ? 1'b0 : i_mem_w_enable;
            end
            ST_WAIT: begin
                o_stall_req = 1'b1;
            end
            ST_DONE: begin
                if (!r_mc_we) begin
                    o_wb_vd       = r_load_q;
                    o_wb_w_enable = i_mem_w_enable;
                end
            end
            default: ;
        endcase
    end

    assign o_mc_req   = r_mc_req;
    assign o_mc_we    = r_mc_we;
    assign o_mc_addr  = r_mc_addr;
    assign o_mc_size  = r_mc_size;
    assign o_mc_wdata = r_mc_wdata;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_LB  = 6'd11;
    localparam logic [5:0] OP_LH  = 6'd12;
    localparam logic [5:0] OP_LW  = 6'd13;
    localparam logic [5:0] OP_LBU = 6'd14;
    localparam logic [5:0] OP_LHU = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd17;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [5:0]  mem_inst;
    logic [4:0]  mem_rd;
    logic [31:0] mem_vd;
    logic        mem_w_enable;
    logic [31:0] mem_addr;
    logic        mc_done;
    logic [31:0] mc_rdata;
    logic        mc_req;
    logic        mc_we;
    logic [31:0] mc_addr;
    logic [1:0]  mc_size;
    logic [31:0] mc_wdata;
    logic [4:0]  wb_rd;
    logic [31:0] wb_vd;
    logic        wb_w_enable;
    logic        stall_req;

    int n_total;
    int n_pass;
    int req_cycles;
    int stall_cycles;

    mem_stage dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_rdy              (rdy),
        .i_mem_inst         (mem_inst),
        .i_mem_rd           (mem_rd),
        .i_mem_vd           (mem_vd),
        .i_mem_w_enable     (mem_w_enable),
        .i_mem_memctrl_addr (mem_addr),
        .i_mc_done          (mc_done),
        .i_mc_rdata         (mc_rdata),
        .o_mc_req           (mc_req),
        .o_mc_we            (mc_we),
        .o_mc_addr          (mc_addr),
        .o_mc_size          (mc_size),
        .o_mc_wdata         (mc_wdata),
        .o_wb_rd            (wb_rd),
        .o_wb_vd            (wb_vd),
        .o_wb_w_enable      (wb_w_enable),
        .o_stall_req        (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_op(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] vd,
                          input logic we, input logic [31:0] addr);
        mem_inst     = op;
        mem_rd       = rd;
        mem_vd       = vd;
        mem_w_enable = we;
        mem_addr     = addr;
    endtask

    // Load with a single-cycle controller response; checks the DONE-cycle write-back value
    task automatic run_load(input string tag, input logic [5:0] op, input logic [31:0] rdata,
                            input logic [31:0] exp_vd);
        @(negedge clk);
        set_op(op, 5'd9, 32'h0, 1'b1, 32'h40);
        #1 chk({tag, "_issue_stall"}, {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        mc_done  = 1'b1;
        mc_rdata = rdata;
        #1 chk({tag, "_wait_req"}, {31'd0, mc_req}, 32'd1);
        @(negedge clk);
        mc_done  = 1'b0;
        mc_rdata = 32'h0;
        #1 chk({tag, "_done_vd"}, wb_vd, exp_vd);
        chk({tag, "_done_we"}, {31'd0, wb_w_enable}, 32'd1);
    endtask

    initial begin
        n_total      = 0;
        n_pass       = 0;
        rst          = 1'b0;
        rdy          = 1'b1;
        mc_done      = 1'b0;
        mc_rdata     = 32'h0;
        set_op(OP_ADD, 5'd0, 32'h0, 1'b0, 32'h0);

        // Reset state
        #1;
        chk("rst_req",   {31'd0, mc_req},   32'd0);
        chk("rst_addr",  mc_addr,           32'd0);
        chk("rst_wdata", mc_wdata,          32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ADD passthrough in the same cycle
        set_op(OP_ADD, 5'd5, 32'h1234, 1'b1, 32'h0);
        #1;
        chk("add_rd",    {27'd0, wb_rd},       32'd5);
        chk("add_vd",    wb_vd,                32'h1234);
        chk("add_we",    {31'd0, wb_w_enable}, 32'd1);
        chk("add_stall", {31'd0, stall_req},   32'd0);

        // LB with controller completing after 3 wait cycles
        @(negedge clk);
        set_op(OP_LB, 5'd7, 32'h0, 1'b1, 32'h100);
        req_cycles   = 0;
        stall_cycles = 0;
        #1;
        chk("lb_issue_we", {31'd0, wb_w_enable}, 32'd0);
        chk("lb_issue_req", {31'd0, mc_req}, 32'd0);
        if (stall_req) stall_cycles++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mc_done  = (i == 3);
            mc_rdata = (i == 3) ? 32'h80 : 32'h0;
            #1;
            if (mc_req) req_cycles++;
            if (stall_req) stall_cycles++;
        end
        chk("lb_addr", mc_addr, 32'h100);
        chk("lb_size", {30'd0, mc_size}, 32'd0);
        chk("lb_mcwe", {31'd0, mc_we}, 32'd0);
        @(negedge clk);
        mc_done  = 1'b0;
        mc_rdata = 32'h0;
        #1;
        if (mc_req) req_cycles++;
        if (stall_req) stall_cycles++;
        chk("lb_req_cycles",   req_cycles,           32'd4);
        chk("lb_stall_cycles", stall_cycles,         32'd5);
        chk("lb_done_vd",      wb_vd,                32'hFFFFFF80);
        chk("lb_done_we",      {31'd0, wb_w_enable}, 32'd1);
        chk("lb_done_rd",      {27'd0, wb_rd},       32'd7);

        // Extension variants, issued back to back
        run_load("lhu", OP_LHU, 32'hBEEF8001, 32'h00008001);
        run_load("lw",  OP_LW,  32'hBEEF8001, 32'hBEEF8001);
        run_load("lh",  OP_LH,  32'h12348001, 32'hFFFF8001);
        run_load("lbu", OP_LBU, 32'hFFFFFF80, 32'h00000080);

        // SH: store data masked to halfword, no write-back
        @(negedge clk);
        set_op(OP_SH, 5'd3, 32'hAABBCCDD, 1'b1, 32'h204);
        #1 chk("sh_issue_stall", {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        mc_done = 1'b1;
        #1;
        chk("sh_mcwe",  {31'd0, mc_we},   32'd1);
        chk("sh_size",  {30'd0, mc_size}, 32'd1);
        chk("sh_wdata", mc_wdata,         32'h0000CCDD);
        chk("sh_addr",  mc_addr,          32'h204);
        @(negedge clk);
        mc_done = 1'b0;
        #1;
        chk("sh_done_we",    {31'd0, wb_w_enable}, 32'd0);
        chk("sh_done_stall", {31'd0, stall_req},   32'd0);

        // Reset asserted mid-WAIT abandons the access immediately
        @(negedge clk);
        set_op(OP_LW, 5'd4, 32'h0, 1'b1, 32'h80);
        @(negedge clk);
        #1 chk("rstw_req_before", {31'd0, mc_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstw_req",   {31'd0, mc_req},    32'd0);
        chk("rstw_stall", {31'd0, stall_req}, 32'd1);
        mem_inst = OP_ADD;
        #1;
        chk("rstw_stall_add", {31'd0, stall_req},   32'd0);
        chk("rstw_we_add",    {31'd0, wb_w_enable}, 32'd1);
        #1 rst = 1'b1;

        // rdy=0 in IDLE blocks issue; rdy=0 during WAIT holds the request
        @(negedge clk);
        set_op(OP_LW, 5'd6, 32'h0, 1'b1, 32'h300);
        rdy = 1'b0;
        @(negedge clk);
        #1 chk("rdy_idle_noissue", {31'd0, mc_req}, 32'd0);
        rdy = 1'b1;
        @(negedge clk);
        #1 chk("rdy_wait_req", {31'd0, mc_req}, 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("rdy_hold_req",   {31'd0, mc_req},    32'd1);
            chk("rdy_hold_addr",  mc_addr,            32'h300);
            chk("rdy_hold_stall", {31'd0, stall_req}, 32'd1);
        end
        rdy      = 1'b1;
        mc_done  = 1'b1;
        mc_rdata = 32'hCAFE0001;
        @(negedge clk);
        mc_done  = 1'b0;
        mc_rdata = 32'h0;
        #1;
        chk("rdy_done_vd",    wb_vd,              32'hCAFE0001);
        chk("rdy_done_stall", {31'd0, stall_req}, 32'd0);
        chk("rdy_done_req",   {31'd0, mc_req},    32'd0);

        // Spurious mc_done while idle has no effect
        @(negedge clk);
        set_op(OP_ADD, 5'd2, 32'h55, 1'b1, 32'h0);
        mc_done  = 1'b1;
        mc_rdata = 32'h999;
        @(negedge clk);
        mc_done = 1'b0;
        #1;
        chk("spur_req",   {31'd0, mc_req},    32'd0);
        chk("spur_stall", {31'd0, stall_req}, 32'd0);
        chk("spur_vd",    wb_vd,              32'h55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
